inst_buffer: RTL

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_pkg.sv | 50 +++++
 rtl/inst_buffer_br_predecode.sv | 29 ++
 rtl/inst_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared fetch/decode definitions: instruction field accessors, branch-class
// encodings and the instruction-buffer entry layout.
package inst_buffer_pkg;

  localparam int XLEN      = 32;
  localparam int EXCCODE_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] FUNC_JR    = 6'h08;
  localparam logic [5:0] FUNC_JALR  = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;
  localparam logic [4:0] RT_BLTZAL  = 5'd16;
  localparam logic [4:0] RT_BGEZAL  = 5'd17;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      inst;
    logic                 exc;
    logic [EXCCODE_W-1:0] exccode;
    logic                 bd;
  } ib_entry_t;

  localparam int ENTRY_W = $bits(ib_entry_t);

  function automatic logic [5:0] get_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [4:0] get_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] get_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

  function automatic logic [15:0] get_imm(input logic [31:0] inst);
    return inst[15:0];
  endfunction

  function automatic logic [5:0] get_func(input logic [31:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/inst_buffer_br_predecode.sv
// Combinational predecode: flags instructions that own a delay slot
// (jr/jalr, REGIMM branches, j/jal/beq/bne/blez/bgtz).
module br_predecode
  import inst_buffer_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_br
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rt;

  assign op   = get_op(inst);
  assign func = get_func(inst);
  assign rt   = get_rt(inst);

  always_comb begin
    is_br = 1'b0;
    if (op == OP_SPECIAL)
      is_br = (func == FUNC_JR) || (func == FUNC_JALR);
    else if (op == OP_REGIMM)
      is_br = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
              (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
    else if ((op >= OP_J) && (op <= OP_BGTZ))
      is_br = 1'b1;
  end

endmodule

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction FIFO; tags each entry with its delay-slot bit
// and counts cycles in which fetch was stalled by a full buffer.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_exc,
  input  logic [EXCCODE_W-1:0]       in_exccode,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_exc,
  output logic [EXCCODE_W-1:0]       out_exccode,
  output logic                       out_bd,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           perfcnt_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ib_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  prev_br_q, prev_br_d;
  logic [CNT_W-1:0]      perf_q, perf_d;

  logic       enq, deq, is_br;
  ib_entry_t  wr_entry, head;

  br_predecode u_predecode (
    .inst  (in_inst),
    .is_br (is_br)
  );

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  always_comb begin
    wr_entry         = '0;
    wr_entry.pc      = in_pc;
    wr_entry.inst    = in_inst;
    wr_entry.exc     = in_exc;
    wr_entry.exccode = in_exccode;
    wr_entry.bd      = prev_br_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    prev_br_d = prev_br_q;
    perf_d    = perf_q;
    // Stall accounting is independent of flush so it survives pipeline redirects.
    if (in_valid && !in_ready)
      perf_d = perf_q + CNT_W'(1);
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      prev_br_d = 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        prev_br_d = in_exc ? 1'b0 : is_br;
      end
      if (deq)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq && !deq)
        count_d = count_q + CW'(1);
      else if (deq && !enq)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      prev_br_q <= 1'b0;
      perf_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      prev_br_q <= prev_br_d;
      perf_q    <= perf_d;
    end
  end

  // Storage is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (enq)
      mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head         = mem_q[rd_ptr_q];
  assign out_pc       = head.pc;
  assign out_inst     = head.inst;
  assign out_exc      = head.exc;
  assign out_exccode  = head.exccode;
  assign out_bd       = head.bd;
  assign count        = count_q;
  assign perfcnt_full = perf_q;

endmodule
